vs_spi_sched: RTL and testbench
===============================

// Module: vs_spi_sched
// PURPOSE
//   Sequencer and bus arbiter for the VS1003 MP3 decoder's shared SPI pins.
//   Pulses hardware reset, writes the MODE, CLOCKF and VOL SCI registers,
//   then streams audio bytes as DREQ-gated SDI bursts.
//   Runtime volume writes (SCI) share the bus with the audio stream; arbitration
//   happens at burst boundaries only. Sits between the audio byte source and the
//   decoder pins in top.
// PARAMETERS
//   CLK_DIV     4        clk cycles per SCLK half-period (>=2)
//   RST_CYCLES  1000     clk cycles xRSET is held low after reset
//   BURST       32       max SDI bytes per DREQ-gated burst
//   INIT_MODE   16'h0804 SCI_MODE (addr 8'h00) init value
//   INIT_CLOCKF 16'h9800 SCI_CLOCKF (addr 8'h03) init value
//   INIT_VOL    16'h2020 SCI_VOL (addr 8'h0B) init value
// PORTS
//   clk        in   1   system clock
//   rst        in   1   synchronous reset, active low
//   DREQ       in   1   decoder ready (1 = can take >=32 bytes / an SCI op)
//   data_in    in   8   audio byte from source
//   data_valid in   1   data_in holds a valid byte
//   data_ready out  1   1-cycle pulse: data_in consumed this cycle
//   vol_req    in   1   level request for a volume write
//   vol_val    in   16  volume word; sampled when the request is granted
//   vol_ack    out  1   1-cycle pulse: volume SCI write finished
//   xRSET      out  1   decoder hardware reset, active low
//   XCS        out  1   SCI chip select, active low
//   XDCS       out  1   SDI chip select, active low
//   SI         out  1   serial data to decoder, MSB first
//   SCLK       out  1   serial clock, idles low
//   ready      out  1   1 once init is done (IDLE and later)
// BEHAVIOUR
//   - All outputs registered. rst=0 at a clk edge: state RST_HOLD, xRSET=0,
//     XCS=1, XDCS=1, SI=0, SCLK=0, data_ready=0, vol_ack=0, ready=0.
//     This also applies mid-transfer: the transfer is aborted, not completed.
//   - SPI mode 0. Per bit, SCLK is low for CLK_DIV cycles, then high for CLK_DIV.
//     SI changes only while SCLK is low. One bit = 2*CLK_DIV clk cycles.
//   - SCI write = 32 bits {8'h02, addr, data16} with XCS low for the whole frame.
//     An SDI byte = 8 bits with XDCS low.
//   - A chip select deasserts CLK_DIV cycles after the last SCLK fall.
//     XCS and XDCS then stay high for >=CLK_DIV cycles before any assertion.
//     XCS and XDCS are never low together.
//   - States:
//       RST_HOLD : xRSET=0 for RST_CYCLES cycles -> WAIT_BOOT.
//       WAIT_BOOT: xRSET=1; wait for DREQ=1 -> INIT.
//       INIT     : writes MODE, CLOCKF, VOL in order. Each write starts only
//                  when DREQ=1. After the third write -> IDLE, ready=1.
//       IDLE     : vol_req=1 (priority) -> SCI_VOL, latching vol_val.
//                  Else DREQ=1 and data_valid=1 -> SDI_BURST.
//                  Else stay in IDLE.
//       SDI_BURST: loading a byte pulses data_ready for 1 cycle, then shifts it.
//                  When a byte completes:
//                  - count<BURST and data_valid=1: load the next byte, XDCS stays low.
//                  - otherwise (BURST bytes sent, or data_valid=0): deassert XDCS
//                    -> IDLE.
//                  DREQ falling mid-burst does not truncate the burst.
//       SCI_VOL  : when DREQ=1, write addr 8'h0B with the latched value; pulse
//                  vol_ack on the cycle XCS returns high -> IDLE.
//   - vol_req asserted during a burst waits for the burst to end. It is never
//     starved: IDLE always checks vol_req first.
//   - Byte counter is $clog2(BURST+1) bits wide and clears on every burst entry.
//     Exactly BURST bytes is the full-burst boundary (no off-by-one overrun).
//   - data_ready never pulses outside SDI_BURST; a byte is never dropped or
//     sent twice.
// TESTING
//   1 Reset, CLK_DIV=4, RST_CYCLES=1000, DREQ=1 -> xRSET low exactly 1000
//     cycles; then three SCI frames 02 00 0804, 02 03 9800, 02 0B 2020
//     (MSB first); then ready=1.
//   2 After init, data_valid=1 continuous, DREQ=1 -> one burst of 32 bytes
//     with XDCS low throughout; 32 data_ready pulses; 8*32 SCLK rises;
//     XDCS high >=4 cycles before the next burst.
//   3 After init, DREQ=0 -> XDCS stays high, no data_ready pulses.
//     DREQ to 1 -> burst starts.
//   4 vol_req with vol_val=16'h4040 raised at byte 5 of a burst -> burst
//     finishes all 32 bytes; then frame 02 0B 4040; then one vol_ack pulse.
//   5 data_valid drops after byte 10 -> XDCS deasserts after byte 10; IDLE;
//     on valid again a new burst restarts the count at 0.
//   6 rst=0 at bit 3 of an SDI byte -> next edge gives XDCS=1, SCLK=0,
//     xRSET=0; the full init sequence repeats.

Source files
------------

// File: rtl/vs_spi_sched.sv
`default_nettype none
// ============================================================================
// vs_spi_sched : VS1003 reset/init sequencer and SCI/SDI shared-bus arbiter
// Rev 1.0
// ============================================================================
module vs_spi_sched #(
   parameter int          CLK_DIV     = 4,
   parameter int          RST_CYCLES  = 1000,
   parameter int          BURST       = 32,
   parameter logic [15:0] INIT_MODE   = 16'h0804,
   parameter logic [15:0] INIT_CLOCKF = 16'h9800,
   parameter logic [15:0] INIT_VOL    = 16'h2020
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        DREQ,
   input  logic [7:0]  data_in,
   input  logic        data_valid,
   output logic        data_ready,
   input  logic        vol_req,
   input  logic [15:0] vol_val,
   output logic        vol_ack,
   output logic        xRSET,
   output logic        XCS,
   output logic        XDCS,
   output logic        SI,
   output logic        SCLK,
   output logic        ready
);

   localparam int c_dw = $clog2(CLK_DIV);
   localparam int c_gw = $clog2(CLK_DIV + 1);
   localparam int c_rw = $clog2(RST_CYCLES + 1);
   localparam int c_cw = $clog2(BURST + 1);
   localparam logic [c_dw-1:0] c_div_last = c_dw'(CLK_DIV - 1);
   localparam logic [c_gw-1:0] c_gap      = c_gw'(CLK_DIV);
   localparam logic [c_rw-1:0] c_rst_last = c_rw'(RST_CYCLES - 1);
   localparam logic [c_cw-1:0] c_burst    = c_cw'(BURST);

   typedef enum logic [2:0] {
      RST_HOLD  = 3'd0,
      WAIT_BOOT = 3'd1,
      INIT      = 3'd2,
      IDLE      = 3'd3,
      SDI_BURST = 3'd4,
      SCI_VOL   = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      PH_IDLE  = 2'd0,
      PH_SHIFT = 2'd1,
      PH_TAIL  = 2'd2
   } phase_t;

   state_t          state_q, state_d;
   phase_t          ph_q, ph_d;
   logic [c_dw-1:0] div_q, div_d;
   logic [c_gw-1:0] gap_q, gap_d;
   logic [c_rw-1:0] rst_cnt_q, rst_cnt_d;
   logic [c_cw-1:0] cnt_q, cnt_d;
   logic [5:0]      bits_q, bits_d;
   logic [31:0]     shift_q, shift_d;
   logic [1:0]      init_idx_q, init_idx_d;
   logic [15:0]     vol_q, vol_d;
   logic            sclk_q, sclk_d;
   logic            xrset_q, xrset_d;
   logic            xcs_q, xcs_d;
   logic            xdcs_q, xdcs_d;
   logic            ready_q, ready_d;
   logic            data_ready_q, data_ready_d;
   logic            vol_ack_q, vol_ack_d;

   logic        gap_ok;
   logic        start_sci;
   logic        load_byte;
   logic [31:0] sci_word;
   logic [31:0] init_word;

   assign gap_ok = (gap_q == c_gap);

   always_comb begin
      case (init_idx_q)
         2'd0:    init_word = {8'h02, 8'h00, INIT_MODE};
         2'd1:    init_word = {8'h02, 8'h03, INIT_CLOCKF};
         default: init_word = {8'h02, 8'h0B, INIT_VOL};
      endcase
   end

   always_comb begin
      state_d      = state_q;
      ph_d         = ph_q;
      div_d        = div_q;
      sclk_d       = sclk_q;
      bits_d       = bits_q;
      shift_d      = shift_q;
      cnt_d        = cnt_q;
      init_idx_d   = init_idx_q;
      rst_cnt_d    = rst_cnt_q;
      vol_d        = vol_q;
      xrset_d      = xrset_q;
      xcs_d        = xcs_q;
      xdcs_d       = xdcs_q;
      ready_d      = ready_q;
      data_ready_d = 1'b0;
      vol_ack_d    = 1'b0;
      start_sci    = 1'b0;
      load_byte    = 1'b0;
      sci_word     = init_word;
      gap_d        = gap_q;
      if (xcs_q && xdcs_q && !gap_ok) gap_d = gap_q + 1'b1;

      case (ph_q)
         PH_SHIFT: begin
            if (div_q == c_div_last) begin
               div_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  sclk_d = 1'b0;
                  if (bits_q == 6'd1) begin
                     // Byte boundary inside a burst: chain the next byte without releasing XDCS
                     if (state_q == SDI_BURST && cnt_q < c_burst && data_valid) load_byte = 1'b1;
                     else ph_d = PH_TAIL;
                  end else begin
                     bits_d  = bits_q - 1'b1;
                     shift_d = {shift_q[30:0], 1'b0};
                  end
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         PH_TAIL: begin
            if (div_q == c_div_last) begin
               div_d   = '0;
               ph_d    = PH_IDLE;
               xcs_d   = 1'b1;
               xdcs_d  = 1'b1;
               gap_d   = '0;
               shift_d = '0;
               case (state_q)
                  INIT: begin
                     if (init_idx_q == 2'd2) begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                     end else begin
                        init_idx_d = init_idx_q + 1'b1;
                     end
                  end
                  SCI_VOL: begin
                     vol_ack_d = 1'b1;
                     state_d   = IDLE;
                  end
                  default: state_d = IDLE;
               endcase
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         default: begin
            case (state_q)
               RST_HOLD: begin
                  if (rst_cnt_q == c_rst_last) begin
                     xrset_d = 1'b1;
                     state_d = WAIT_BOOT;
                  end else begin
                     rst_cnt_d = rst_cnt_q + 1'b1;
                  end
               end
               WAIT_BOOT: if (DREQ) state_d = INIT;
               INIT:      if (DREQ && gap_ok) start_sci = 1'b1;
               IDLE: begin
                  if (vol_req) begin
                     state_d = SCI_VOL;
                     vol_d   = vol_val;
                  end else if (DREQ && data_valid && gap_ok) begin
                     state_d   = SDI_BURST;
                     load_byte = 1'b1;
                  end
               end
               SCI_VOL: begin
                  sci_word = {8'h02, 8'h0B, vol_q};
                  if (DREQ && gap_ok) start_sci = 1'b1;
               end
               default: ;
            endcase
         end
      endcase

      if (start_sci) begin
         ph_d    = PH_SHIFT;
         xcs_d   = 1'b0;
         shift_d = sci_word;
         bits_d  = 6'd32;
         div_d   = '0;
         sclk_d  = 1'b0;
      end
      if (load_byte) begin
         ph_d         = PH_SHIFT;
         xdcs_d       = 1'b0;
         shift_d      = {data_in, 24'h0};
         bits_d       = 6'd8;
         div_d        = '0;
         sclk_d       = 1'b0;
         data_ready_d = 1'b1;
         cnt_d        = (state_q == SDI_BURST) ? cnt_q + 1'b1 : c_cw'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= RST_HOLD;
         ph_q         <= PH_IDLE;
         div_q        <= '0;
         gap_q        <= '0;
         rst_cnt_q    <= '0;
         cnt_q        <= '0;
         bits_q       <= '0;
         shift_q      <= '0;
         init_idx_q   <= '0;
         vol_q        <= '0;
         sclk_q       <= 1'b0;
         xrset_q      <= 1'b0;
         xcs_q        <= 1'b1;
         xdcs_q       <= 1'b1;
         ready_q      <= 1'b0;
         data_ready_q <= 1'b0;
         vol_ack_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         ph_q         <= ph_d;
         div_q        <= div_d;
         gap_q        <= gap_d;
         rst_cnt_q    <= rst_cnt_d;
         cnt_q        <= cnt_d;
         bits_q       <= bits_d;
         shift_q      <= shift_d;
         init_idx_q   <= init_idx_d;
         vol_q        <= vol_d;
         sclk_q       <= sclk_d;
         xrset_q      <= xrset_d;
         xcs_q        <= xcs_d;
         xdcs_q       <= xdcs_d;
         ready_q      <= ready_d;
         data_ready_q <= data_ready_d;
         vol_ack_q    <= vol_ack_d;
      end
   end

   assign data_ready = data_ready_q;
   assign vol_ack    = vol_ack_q;
   assign xRSET      = xrset_q;
   assign XCS        = xcs_q;
   assign XDCS       = xdcs_q;
   assign SI         = shift_q[31];
   assign SCLK       = sclk_q;
   assign ready      = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_vs_spi_sched.sv
`default_nettype none
// ============================================================================
// tb_vs_spi_sched : directed self-checking bench for vs_spi_sched
// Rev 1.0
// ============================================================================
module tb_vs_spi_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        DREQ = 1'b1;
   logic [7:0]  data_in = 8'h00;
   logic        data_valid = 1'b0;
   logic        vol_req = 1'b0;
   logic [15:0] vol_val = 16'h0000;
   logic        data_ready, vol_ack, xRSET, XCS, XDCS, SI, SCLK, ready;

   always #5 clk = ~clk;

   vs_spi_sched #(
      .CLK_DIV    (4),
      .RST_CYCLES (1000),
      .BURST      (32)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .DREQ       (DREQ),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .vol_req    (vol_req),
      .vol_val    (vol_val),
      .vol_ack    (vol_ack),
      .xRSET      (xRSET),
      .XCS        (XCS),
      .XDCS       (XDCS),
      .SI         (SI),
      .SCLK       (SCLK),
      .ready      (ready)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   // Audio byte source: byte value = running index, advanced on each data_ready.
   int src_cnt   = 0;
   int src_limit = 0;
   bit src_en    = 1'b0;
   initial forever begin
      @(negedge clk);
      if (data_ready) src_cnt++;
      data_in    = 8'(src_cnt);
      data_valid = src_en && (src_cnt < src_limit);
   end

   // Bus monitor: decodes SCI frames and SDI bytes from the pins.
   logic [31:0] sci_q[$];
   int          burst_q[$];
   logic [31:0] sci_sh = '0;
   logic [7:0]  sdi_sh = '0;
   logic [7:0]  exp_rx = '0;
   int sci_n = 0, sdi_n = 0, burst_bytes = 0, sdi_rises = 0;
   int rx_bad = 0, sci_len_bad = 0, both_low = 0, dr_cnt = 0, vol_ack_cnt = 0;
   int gap_run = 0, min_gap = 1000000;
   logic sclk_p = 1'b0, xcs_p = 1'b1, xdcs_p = 1'b1;
   initial forever begin
      @(negedge clk);
      if (!XCS && !XDCS) both_low++;
      if (data_ready) dr_cnt++;
      if (vol_ack) vol_ack_cnt++;
      if (SCLK && !sclk_p) begin
         if (!XCS) begin
            sci_sh = {sci_sh[30:0], SI};
            sci_n++;
         end
         if (!XDCS) begin
            sdi_rises++;
            sdi_sh = {sdi_sh[6:0], SI};
            sdi_n++;
            if (sdi_n == 8) begin
               sdi_n = 0;
               burst_bytes++;
               if (sdi_sh !== exp_rx) rx_bad++;
               exp_rx++;
            end
         end
      end
      if (XCS && !xcs_p) begin
         if (sci_n != 32) sci_len_bad++;
         sci_q.push_back(sci_sh);
         sci_n = 0;
      end
      if (XDCS && !xdcs_p) begin
         if (sdi_n != 0) exp_rx++;
         sdi_n = 0;
         burst_q.push_back(burst_bytes);
         burst_bytes = 0;
      end
      if (XCS && XDCS) gap_run++;
      else begin
         if (gap_run > 0 && gap_run < min_gap) min_gap = gap_run;
         gap_run = 0;
      end
      sclk_p = SCLK;
      xcs_p  = XCS;
      xdcs_p = XDCS;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_burst(input string tag, output int len);
      len = -1;
      for (int k = 0; k < 6000; k++) begin
         tick();
         if (burst_q.size() > 0) begin
            len = burst_q.pop_front();
            return;
         end
      end
      check_eq({tag, "_timeout"}, 0, 1);
   endtask

   task automatic wait_quiet(input string tag);
      int run;
      run = 0;
      for (int k = 0; k < 8000; k++) begin
         tick();
         if (XCS && XDCS) run++;
         else run = 0;
         if (run >= 50) return;
      end
      check_eq({tag, "_quiet_timeout"}, 0, 1);
   endtask

   task automatic check_init(input string tag);
      int          lo;
      logic [31:0] fr;
      logic [31:0] exp_fr[3];
      exp_fr[0] = 32'h0200_0804;
      exp_fr[1] = 32'h0203_9800;
      exp_fr[2] = 32'h020B_2020;
      lo = 0;
      for (int k = 0; k < 3000; k++) begin
         tick();
         if (xRSET == 1'b0) lo++;
         else break;
      end
      check_eq({tag, "_xrset_low"}, lo, 1000);
      for (int k = 0; k < 3000 && !ready; k++) tick();
      check_eq({tag, "_ready"}, ready, 1'b1);
      check_eq({tag, "_frames"}, sci_q.size(), 3);
      for (int i = 0; i < 3; i++) begin
         fr = (sci_q.size() > 0) ? sci_q.pop_front() : 32'hDEAD_DEAD;
         check_eq($sformatf("%s_frame%0d", tag, i), fr, exp_fr[i]);
      end
   endtask

   int len, d0, r0, a0, g;

   initial begin
      // 1: reset and init sequence
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_pins", {xRSET, XCS, XDCS, SI, SCLK}, 5'b01100);
      check_eq("rst_flags", {data_ready, vol_ack, ready}, 3'b000);
      rst = 1'b1;
      check_init("init");

      // 2: continuous data, full burst
      src_limit = 1000000;
      d0 = dr_cnt;
      r0 = sdi_rises;
      src_en = 1'b1;
      wait_burst("burst1", len);
      check_eq("burst1_len", len, 32);
      check_eq("burst1_dready", dr_cnt - d0, 32);
      check_eq("burst1_sclk", sdi_rises - r0, 256);
      g = 0;
      for (int k = 0; k < 200 && XDCS; k++) begin
         g++;
         tick();
      end
      check_eq("burst_gap", (g >= 4 && g < 200), 1'b1);
      src_en = 1'b0;
      wait_quiet("t2");
      burst_q.delete();

      // 3: DREQ low holds off bursts
      DREQ   = 1'b0;
      src_en = 1'b1;
      d0 = dr_cnt;
      g  = 0;
      for (int k = 0; k < 200; k++) begin
         tick();
         if (!XDCS) g++;
      end
      check_eq("dreq0_dready", dr_cnt - d0, 0);
      check_eq("dreq0_xdcs", g, 0);
      DREQ = 1'b1;
      wait_burst("dreq1", len);
      check_eq("dreq1_len", len, 32);

      // 4: volume request mid-burst waits for the burst
      d0 = dr_cnt;
      a0 = vol_ack_cnt;
      for (int k = 0; k < 3000 && dr_cnt < d0 + 5; k++) tick();
      vol_req = 1'b1;
      vol_val = 16'h4040;
      wait_burst("volburst", len);
      check_eq("volburst_len", len, 32);
      check_eq("vol_before_end", sci_q.size(), 0);
      for (int k = 0; k < 3000 && vol_ack_cnt == a0; k++) tick();
      vol_req = 1'b0;
      check_eq("vol_frame_cnt", sci_q.size(), 1);
      check_eq("vol_frame", (sci_q.size() > 0) ? sci_q.pop_front() : 32'hDEAD_DEAD, 32'h020B_4040);
      src_en = 1'b0;
      wait_quiet("t4");
      check_eq("vol_ack_pulses", vol_ack_cnt - a0, 1);
      burst_q.delete();

      // 5: data_valid drops after byte 10, then a fresh full burst
      src_limit = src_cnt + 10;
      src_en    = 1'b1;
      wait_burst("short", len);
      check_eq("short_len", len, 10);
      d0 = dr_cnt;
      repeat (100) tick();
      check_eq("short_idle_dready", dr_cnt - d0, 0);
      check_eq("short_idle_xdcs", XDCS, 1'b1);
      src_limit = src_cnt + 1000;
      wait_burst("restart", len);
      check_eq("restart_len", len, 32);

      // 6: reset in the middle of an SDI byte
      for (int k = 0; k < 3000 && !(sdi_n == 3 && !XDCS); k++) tick();
      check_eq("midbyte_reached", sdi_n, 3);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_eq("abort_pins", {xRSET, XCS, XDCS, SCLK}, 4'b0110);
      check_eq("abort_ready", ready, 1'b0);
      rst = 1'b1;
      sci_q.delete();
      check_init("reinit");
      burst_q.delete();

      check_eq("sdi_bytes_bad", rx_bad, 0);
      check_eq("sci_len_bad", sci_len_bad, 0);
      check_eq("cs_both_low", both_low, 0);
      check_eq("cs_gap_min", min_gap >= 4, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
